// File: rtl/arriskv_pkg.sv
// Shared types for the arriskv execute stage: ALU opcode encoding, FSM states
// and the helper that classifies multiply/divide opcodes.
package arriskv_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLT    = 5'd5,
      OP_SLTU   = 5'd6,
      OP_SLL    = 5'd7,
      OP_SRL    = 5'd8,
      OP_SRA    = 5'd9,
      OP_LUI    = 5'd10,
      OP_AUIPC  = 5'd11,
      OP_MUL    = 5'd12,
      OP_MULH   = 5'd13,
      OP_MULHSU = 5'd14,
      OP_MULHU  = 5'd15,
      OP_DIV    = 5'd16,
      OP_DIVU   = 5'd17,
      OP_REM    = 5'd18,
      OP_REMU   = 5'd19
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   function automatic logic is_muldiv_op(input alu_op_t op);
      return (op >= OP_MUL) && (op <= OP_REMU);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on operand
// magnitudes, one step per cycle, sign fix-up on the way out. Built only with ARRISKV_MULDIV_EN.
`ifdef ARRISKV_MULDIV_EN
module alu_muldiv_iter
   import arriskv_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         step,
   input  alu_op_t      op,
   input  logic [W-1:0] arg1,
   input  logic [W-1:0] arg2,
   output logic         early_done,
   output logic [W-1:0] result
);

   logic [2*W-1:0] acc, acc_next, prod;
   logic [W-1:0]   opnd, mag_a, mag_b, quo, rem;
   logic [W:0]     sum, shifted, diff;
   logic           is_mul, sel_hi, neg_lo, neg_hi;
   logic           sgn_a, sgn_b, div_op, div_zero, div_ovf;

   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      case (op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            sgn_a = arg1[W-1];
            sgn_b = arg2[W-1];
         end
         OP_MULHSU: sgn_a = arg1[W-1];
         default: ;
      endcase
   end

   assign mag_a      = sgn_a ? -arg1 : arg1;
   assign mag_b      = sgn_b ? -arg2 : arg2;
   assign div_op     = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   assign div_zero   = div_op && (arg2 == '0);
   assign div_ovf    = (op == OP_DIV || op == OP_REM) &&
                       (arg1 == {1'b1, {(W-1){1'b0}}}) && (arg2 == '1);
   assign early_done = div_zero || div_ovf;

   // acc is {high, low}: product accumulates in place; for divide high is the
   // partial remainder and low shifts dividend bits out and quotient bits in.
   always_comb begin
      sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted = acc[2*W-1:W-1];
      diff    = shifted - {1'b0, opnd};
      if (is_mul)
         acc_next = {sum, acc[W-1:1]};
      else if (!diff[W])
         acc_next = {diff[W-1:0], acc[W-2:0], 1'b1};
      else
         acc_next = {shifted[W-1:0], acc[W-2:0], 1'b0};
   end

   assign prod   = neg_lo ? -acc : acc;
   assign quo    = neg_lo ? -acc[W-1:0] : acc[W-1:0];
   assign rem    = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
   assign result = is_mul ? (sel_hi ? prod[2*W-1:W] : prod[W-1:0])
                          : (sel_hi ? rem : quo);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         opnd   <= '0;
         is_mul <= 1'b0;
         sel_hi <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
      end else if (start) begin
         is_mul <= !div_op;
         sel_hi <= op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
         opnd   <= mag_b;
         if (early_done) begin
            // Boundary answers are preloaded as {remainder, quotient}, no sign fix-up.
            acc    <= div_zero ? {arg1, {W{1'b1}}} : {{W{1'b0}}, arg1};
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
         end else begin
            acc    <= {{W{1'b0}}, mag_a};
            neg_lo <= sgn_a ^ sgn_b;
            neg_hi <= sgn_a;
         end
      end else if (step) begin
         acc <= acc_next;
      end
   end

endmodule
`endif

// File: rtl/alu_mdu.sv
// arriskv execute unit: single-cycle RV32I ALU plus optional iterative RV32M
// (enabled by defining ARRISKV_MULDIV_EN), valid/ready handshake on both sides.
module alu_mdu
   import arriskv_pkg::*;
#(
   parameter int unsigned wd_regs_p = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  alu_op_t              i_op,
   input  logic [wd_regs_p-1:0] i_arg1,
   input  logic [wd_regs_p-1:0] i_arg2,
   input  logic [wd_regs_p-1:0] i_pc,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [wd_regs_p-1:0] o_result,
   output logic [wd_regs_p-1:0] o_pc,
   output logic                 o_illegal
);

   localparam int unsigned SH_W = $clog2(wd_regs_p);

   logic [SH_W-1:0]      shamt;
   logic [wd_regs_p-1:0] alu_res;
   logic                 alu_illegal;
   logic                 accept, take;

   assign shamt  = i_arg2[SH_W-1:0];
   assign accept = i_valid && o_ready;
   assign take   = o_valid && i_ready;

   // Multiply/divide opcodes land in default here; with the datapath built they
   // are steered away before this result is used.
   always_comb begin
      alu_res     = '0;
      alu_illegal = 1'b0;
      case (i_op)
         OP_ADD:   alu_res = i_arg1 + i_arg2;
         OP_SUB:   alu_res = i_arg1 - i_arg2;
         OP_AND:   alu_res = i_arg1 & i_arg2;
         OP_OR:    alu_res = i_arg1 | i_arg2;
         OP_XOR:   alu_res = i_arg1 ^ i_arg2;
         OP_SLT:   alu_res = {{(wd_regs_p-1){1'b0}}, ($signed(i_arg1) < $signed(i_arg2))};
         OP_SLTU:  alu_res = {{(wd_regs_p-1){1'b0}}, (i_arg1 < i_arg2)};
         OP_SLL:   alu_res = i_arg1 << shamt;
         OP_SRL:   alu_res = i_arg1 >> shamt;
         OP_SRA:   alu_res = $unsigned($signed(i_arg1) >>> shamt);
         OP_LUI:   alu_res = i_arg2;
         OP_AUIPC: alu_res = i_pc + i_arg2;
         default:  alu_illegal = 1'b1;
      endcase
   end

`ifdef ARRISKV_MULDIV_EN
   alu_state_t           state;
   logic [SH_W-1:0]      count;
   logic                 md_start, md_early;
   logic [wd_regs_p-1:0] md_result;

   assign md_start = accept && is_muldiv_op(i_op);
   assign o_ready  = (state == IDLE) && (!o_valid || i_ready);

   alu_muldiv_iter #(.W(wd_regs_p)) u_iter (
      .clk        (clk),
      .rst        (rst),
      .start      (md_start),
      .step       (state == CALC),
      .op         (i_op),
      .arg1       (i_arg1),
      .arg2       (i_arg2),
      .early_done (md_early),
      .result     (md_result)
   );
`else
   assign o_ready = !o_valid || i_ready;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid   <= 1'b0;
         o_result  <= '0;
         o_pc      <= '0;
         o_illegal <= 1'b0;
`ifdef ARRISKV_MULDIV_EN
         state     <= IDLE;
         count     <= '0;
`endif
      end else begin
`ifdef ARRISKV_MULDIV_EN
         case (state)
            CALC: begin
               count <= count - 1'b1;
               if (count == '0) state <= DONE;
            end
            DONE: begin
               o_result  <= md_result;
               o_illegal <= 1'b0;
               o_valid   <= 1'b1;
               state     <= IDLE;
            end
            default: ;
         endcase
`endif
         // NOTE: a later non-blocking assignment wins, so an accept in the same
         // cycle as a take overrides the clear of o_valid below.
         if (take) o_valid <= 1'b0;
         if (accept) begin
            o_pc <= i_pc;
`ifdef ARRISKV_MULDIV_EN
            if (is_muldiv_op(i_op)) begin
               state <= md_early ? DONE : CALC;
               count <= SH_W'(wd_regs_p - 1);
            end else
`endif
            begin
               o_result  <= alu_res;
               o_illegal <= alu_illegal;
               o_valid   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed single-cycle vector table plus
// hand-written handshake, multiply/divide and reset sequences.
module tb_alu_mdu;
   import arriskv_pkg::*;

   logic        clk, rst;
   logic        i_valid, o_ready, o_valid, i_ready, o_illegal;
   alu_op_t     i_op;
   logic [31:0] i_arg1, i_arg2, i_pc, o_result, o_pc;

   int checks = 0;
   int errors = 0;

   alu_mdu #(.wd_regs_p(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_op      (i_op),
      .i_arg1    (i_arg1),
      .i_arg2    (i_arg2),
      .i_pc      (i_pc),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_result  (o_result),
      .o_pc      (o_pc),
      .o_illegal (o_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] exp;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input alu_op_t op, input logic [31:0] a, b, pc);
      i_valid = 1'b1;
      i_op    = op;
      i_arg1  = a;
      i_arg2  = b;
      i_pc    = pc;
   endtask

   // Issue one request with i_ready held high, measure latency, check the result,
   // then let the result drain. Caller guarantees the unit is idle and empty.
   task automatic run_op(input string name, input alu_op_t op, input logic [31:0] a, b, pc,
                         input logic [31:0] exp, input logic ill, input int lat);
      int n;
      i_ready = 1'b1;
      drive(op, a, b, pc);
      @(posedge clk); #1;
      i_valid = 1'b0;
      n = 1;
      if (lat > 1) check({name, " busy_ready"}, o_ready, 0);
      while (!o_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " latency"}, n, lat);
      check({name, " result"}, o_result, exp);
      check({name, " illegal"}, o_illegal, ill);
      check({name, " pc"}, o_pc, pc);
      @(posedge clk); #1;
   endtask

   initial begin
      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_op    = OP_ADD;
      i_arg1  = '0;
      i_arg2  = '0;
      i_pc    = '0;

      vecs.push_back('{"add",      OP_ADD,   32'd5,        32'd7,        32'h200, 32'd12,       1'b0});
      vecs.push_back('{"sub",      OP_SUB,   32'd5,        32'd7,        32'h204, 32'hFFFF_FFFE, 1'b0});
      vecs.push_back('{"and",      OP_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h208, 32'h0000_F000, 1'b0});
      vecs.push_back('{"or",       OP_OR,    32'h0000_F0F0, 32'h0000_FF00, 32'h20C, 32'h0000_FFF0, 1'b0});
      vecs.push_back('{"xor",      OP_XOR,   32'h0000_F0F0, 32'h0000_FF00, 32'h210, 32'h0000_0FF0, 1'b0});
      vecs.push_back('{"slt_neg",  OP_SLT,   32'hFFFF_FFFF, 32'd1,        32'h214, 32'd1,        1'b0});
      vecs.push_back('{"slt_pos",  OP_SLT,   32'd1,        32'hFFFF_FFFF, 32'h218, 32'd0,        1'b0});
      vecs.push_back('{"sltu_big", OP_SLTU,  32'hFFFF_FFFF, 32'd1,        32'h21C, 32'd0,        1'b0});
      vecs.push_back('{"sltu_sml", OP_SLTU,  32'd1,        32'hFFFF_FFFF, 32'h220, 32'd1,        1'b0});
      vecs.push_back('{"sll_mask", OP_SLL,   32'd1,        32'h25,       32'h224, 32'd32,       1'b0});
      vecs.push_back('{"srl",      OP_SRL,   32'h8000_0000, 32'd4,        32'h228, 32'h0800_0000, 1'b0});
      vecs.push_back('{"sra",      OP_SRA,   32'h8000_0000, 32'd4,        32'h22C, 32'hF800_0000, 1'b0});
      vecs.push_back('{"lui",      OP_LUI,   32'hDEAD_BEEF, 32'h1234_5000, 32'h230, 32'h1234_5000, 1'b0});
      vecs.push_back('{"auipc",    OP_AUIPC, 32'd0,        32'h1000,     32'h100, 32'h1100,     1'b0});
      vecs.push_back('{"bad_op",   alu_op_t'(5'd31), 32'd3, 32'd4,       32'h234, 32'd0,        1'b1});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst o_valid", o_valid, 0);
      check("rst o_result", o_result, 0);
      check("rst o_pc", o_pc, 0);
      check("rst o_illegal", o_illegal, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst o_ready", o_ready, 1);
      @(posedge clk); #1;

      // Vector table, issued back-to-back
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc);
         @(posedge clk); #1;
         check({vecs[i].name, " valid"}, o_valid, 1);
         check({vecs[i].name, " result"}, o_result, vecs[i].exp);
         check({vecs[i].name, " illegal"}, o_illegal, vecs[i].ill);
         check({vecs[i].name, " pc"}, o_pc, vecs[i].pc);
      end
      i_valid = 1'b0;
      @(posedge clk); #1;
      check("drain valid", o_valid, 0);

      // Ten back-to-back ADDs
      for (int i = 0; i < 10; i++) begin
         drive(OP_ADD, 32'(i), 32'd100, 32'h300 + 32'(4 * i));
         @(posedge clk); #1;
         check($sformatf("b2b%0d valid", i), o_valid, 1);
         check($sformatf("b2b%0d result", i), o_result, 32'd100 + 32'(i));
      end
      i_valid = 1'b0;
      @(posedge clk); #1;

      // Downstream stall for 3 cycles with a second request waiting
      i_ready = 1'b0;
      drive(OP_ADD, 32'd1, 32'd1, 32'h40);
      @(posedge clk); #1;
      drive(OP_ADD, 32'd2, 32'd2, 32'h44);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall%0d ready", i), o_ready, 0);
         check($sformatf("stall%0d valid", i), o_valid, 1);
         check($sformatf("stall%0d result", i), o_result, 32'd2);
         check($sformatf("stall%0d pc", i), o_pc, 32'h40);
         @(posedge clk); #1;
      end
      i_ready = 1'b1;
      #1;
      check("unstall ready", o_ready, 1);
      @(posedge clk); #1;
      check("unstall result", o_result, 32'd4);
      check("unstall pc", o_pc, 32'h44);
      check("unstall valid", o_valid, 1);
      i_valid = 1'b0;
      @(posedge clk); #1;
      check("unstall drain", o_valid, 0);

`ifdef ARRISKV_MULDIV_EN
      run_op("mulh",    OP_MULH,   32'h8000_0000, 32'd2,        32'h500, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("mulhu",   OP_MULHU,  32'h8000_0000, 32'd2,        32'h504, 32'h0000_0001, 1'b0, 34);
      run_op("mul",     OP_MUL,    32'hFFFF_FFFD, 32'd5,        32'h508, 32'hFFFF_FFF1, 1'b0, 34);
      run_op("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h50C, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("div_0",   OP_DIV,    32'd7,         32'd0,        32'h510, 32'hFFFF_FFFF, 1'b0, 2);
      run_op("rem_0",   OP_REM,    32'd7,         32'd0,        32'h514, 32'd7,         1'b0, 2);
      run_op("div_ovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h518, 32'h8000_0000, 1'b0, 2);
      run_op("rem_ovf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h51C, 32'd0,         1'b0, 2);
      run_op("div_neg", OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'h520, 32'hFFFF_FFFD, 1'b0, 34);
      run_op("rem_neg", OP_REM,    32'hFFFF_FFF9, 32'd2,        32'h524, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("divu",    OP_DIVU,   32'd100,       32'd7,        32'h528, 32'd14,        1'b0, 34);
      run_op("remu",    OP_REMU,   32'd100,       32'd7,        32'h52C, 32'd2,         1'b0, 34);
`else
      run_op("mul_off", OP_MUL,    32'd3,         32'd4,        32'h500, 32'd0,         1'b1, 1);
      run_op("divu_off", OP_DIVU,  32'd100,       32'd7,        32'h504, 32'd0,         1'b1, 1);
`endif

      // Reset in the middle of a DIVU
      run_op("pre_rst add", OP_ADD, 32'd9, 32'd9, 32'h600, 32'd18, 1'b0, 1);
      drive(OP_DIVU, 32'd100, 32'd7, 32'h604);
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort o_valid", o_valid, 0);
      check("abort o_result", o_result, 0);
      check("abort o_pc", o_pc, 0);
      check("abort o_illegal", o_illegal, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort o_ready", o_ready, 1);
      check("abort no result", o_valid, 0);
      run_op("post_rst add", OP_ADD, 32'd2, 32'd3, 32'h700, 32'd5, 1'b0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
